// File: rtl/riscv_defines.sv
// Shared types for the decode/execute boundary: ALU ops, operand-A and forward selects.
package riscv_defines;

    localparam int unsigned ALU_OP_WIDTH = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } op_a_sel_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_WB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Forwarding select for one source register: EX/MEM beats MEM/WB beats regfile; x0 reads 0.
module operand_fwd_mux
    import riscv_defines::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [DATA_WIDTH-1:0]     i_rf_data,
    input  logic                      i_ex_fwd_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     i_ex_fwd_data,
    input  logic                      i_ex_is_load,
    input  logic                      i_wb_fwd_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_wb_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     i_wb_fwd_data,
    output logic [DATA_WIDTH-1:0]     o_fwd_data_c,
    output fwd_sel_t                  o_fwd_sel_c
);

    logic rs_nonzero;
    logic ex_match;
    logic wb_match;

    // A load in EX has no data yet, so it never forwards (the stall covers it).
    assign rs_nonzero = (i_rs_addr != '0);
    assign ex_match   = i_ex_fwd_valid && (i_ex_fwd_rd == i_rs_addr) && rs_nonzero && !i_ex_is_load;
    assign wb_match   = i_wb_fwd_valid && (i_wb_fwd_rd == i_rs_addr) && rs_nonzero;

    // Priority select of the source value.
    always_comb begin
        o_fwd_sel_c  = FWD_RF;
        o_fwd_data_c = i_rf_data;
        if (!rs_nonzero) begin
            o_fwd_data_c = '0;
        end else if (ex_match) begin
            o_fwd_sel_c  = FWD_EX;
            o_fwd_data_c = i_ex_fwd_data;
        end else if (wb_match) begin
            o_fwd_sel_c  = FWD_WB;
            o_fwd_data_c = i_wb_fwd_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand select, forwarding, load-use stall and flush.
module id_ex_stage
    import riscv_defines::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  alu_op_t                   i_alu_op,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
    input  logic                      i_rs1_used,
    input  logic                      i_rs2_used,
    input  logic [DATA_WIDTH-1:0]     i_rs1_data,
    input  logic [DATA_WIDTH-1:0]     i_rs2_data,
    input  logic [DATA_WIDTH-1:0]     i_imm,
    input  logic [DATA_WIDTH-1:0]     i_pc,
    input  op_a_sel_t                 i_op_a_sel,
    input  logic                      i_op_b_imm,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                      i_rd_we,
    input  logic                      i_is_load,
    input  logic                      i_ex_fwd_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     i_ex_fwd_data,
    input  logic                      i_ex_is_load,
    input  logic                      i_wb_fwd_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_wb_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     i_wb_fwd_data,
    input  logic                      i_flush,
    output logic                      o_valid,
    input  logic                      i_ready,
    output alu_op_t                   o_alu_op,
    output logic [DATA_WIDTH-1:0]     o_operand_a,
    output logic [DATA_WIDTH-1:0]     o_operand_b,
    output logic [DATA_WIDTH-1:0]     o_rs2_fwd,
    output logic [DATA_WIDTH-1:0]     o_pc,
    output logic [DATA_WIDTH-1:0]     o_imm,
    output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
    output logic                      o_rd_we,
    output logic                      o_is_load
);

    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    fwd_sel_t              rs1_sel;
    fwd_sel_t              rs2_sel;
    logic [DATA_WIDTH-1:0] operand_a_c;
    logic [DATA_WIDTH-1:0] operand_b_c;
    logic                  load_use_stall;
    logic                  advance;
    logic                  capture;

    operand_fwd_mux #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_rs1_fwd (
        .i_rs_addr     (i_rs1_addr),
        .i_rf_data     (i_rs1_data),
        .i_ex_fwd_valid(i_ex_fwd_valid),
        .i_ex_fwd_rd   (i_ex_fwd_rd),
        .i_ex_fwd_data (i_ex_fwd_data),
        .i_ex_is_load  (i_ex_is_load),
        .i_wb_fwd_valid(i_wb_fwd_valid),
        .i_wb_fwd_rd   (i_wb_fwd_rd),
        .i_wb_fwd_data (i_wb_fwd_data),
        .o_fwd_data_c  (rs1_val),
        .o_fwd_sel_c   (rs1_sel)
    );

    operand_fwd_mux #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_rs2_fwd (
        .i_rs_addr     (i_rs2_addr),
        .i_rf_data     (i_rs2_data),
        .i_ex_fwd_valid(i_ex_fwd_valid),
        .i_ex_fwd_rd   (i_ex_fwd_rd),
        .i_ex_fwd_data (i_ex_fwd_data),
        .i_ex_is_load  (i_ex_is_load),
        .i_wb_fwd_valid(i_wb_fwd_valid),
        .i_wb_fwd_rd   (i_wb_fwd_rd),
        .i_wb_fwd_data (i_wb_fwd_data),
        .o_fwd_data_c  (rs2_val),
        .o_fwd_sel_c   (rs2_sel)
    );

    // The load's data only exists after MEM, so a dependent instruction must wait a cycle.
    assign load_use_stall = i_valid && i_ex_fwd_valid && i_ex_is_load && (i_ex_fwd_rd != '0) &&
                            ((i_rs1_used && (i_rs1_addr == i_ex_fwd_rd)) ||
                             (i_rs2_used && (i_rs2_addr == i_ex_fwd_rd)));
    assign advance = !o_valid || i_ready;
    assign o_ready = advance && !load_use_stall;
    assign capture = i_valid && o_ready;

    // Operand A/B selection from forwarded registers, PC and immediate.
    always_comb begin
        operand_a_c = rs1_val;
        case (i_op_a_sel)
            OPA_PC:   operand_a_c = i_pc;
            OPA_ZERO: operand_a_c = '0;
            default:  operand_a_c = rs1_val;
        endcase
        operand_b_c = i_op_b_imm ? i_imm : rs2_val;
    end

    // Debug-select sanity: x0 is never sourced from a forwarding path.
    always_comb begin
        assert ((i_rs1_addr != '0) || (rs1_sel == FWD_RF));
        assert ((i_rs2_addr != '0) || (rs2_sel == FWD_RF));
    end

    // Pipeline register: flush beats capture/hold; advance either captures or loads a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_alu_op    <= ALU_NOP;
            o_operand_a <= '0;
            o_operand_b <= '0;
            o_rs2_fwd   <= '0;
            o_pc        <= '0;
            o_imm       <= '0;
            o_rd_addr   <= '0;
            o_rd_we     <= 1'b0;
            o_is_load   <= 1'b0;
        end else if (i_flush) begin
            o_valid   <= 1'b0;
            o_alu_op  <= ALU_NOP;
            o_rd_we   <= 1'b0;
            o_is_load <= 1'b0;
        end else if (advance) begin
            if (capture) begin
                o_valid     <= 1'b1;
                o_alu_op    <= i_alu_op;
                o_operand_a <= operand_a_c;
                o_operand_b <= operand_b_c;
                o_rs2_fwd   <= rs2_val;
                o_pc        <= i_pc;
                o_imm       <= i_imm;
                o_rd_addr   <= i_rd_addr;
                o_rd_we     <= i_rd_we;
                o_is_load   <= i_is_load;
            end else begin
                o_valid   <= 1'b0;
                o_alu_op  <= ALU_NOP;
                o_rd_we   <= 1'b0;
                o_is_load <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_id_ex_stage;
    import riscv_defines::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 0, i_rs1_used = 0, i_rs2_used = 0, i_op_b_imm = 0;
    logic          i_rd_we = 0, i_is_load = 0, i_ex_fwd_valid = 0, i_ex_is_load = 0;
    logic          i_wb_fwd_valid = 0, i_flush = 0, i_ready = 0;
    alu_op_t       i_alu_op = ALU_NOP;
    op_a_sel_t     i_op_a_sel = OPA_RS1;
    logic [AW-1:0] i_rs1_addr = 0, i_rs2_addr = 0, i_rd_addr = 0, i_ex_fwd_rd = 0, i_wb_fwd_rd = 0;
    logic [DW-1:0] i_rs1_data = 0, i_rs2_data = 0, i_imm = 0, i_pc = 0, i_ex_fwd_data = 0, i_wb_fwd_data = 0;

    logic          o_ready, o_valid, o_rd_we, o_is_load;
    alu_op_t       o_alu_op;
    logic [DW-1:0] o_operand_a, o_operand_b, o_rs2_fwd, o_pc, o_imm;
    logic [AW-1:0] o_rd_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the execute stage should currently be holding.
    logic          m_valid, m_we, m_load, exp_ready, obs_ready;
    alu_op_t       m_op;
    logic [DW-1:0] m_a, m_b, m_rs2, m_pc, m_imm;
    logic [AW-1:0] m_rd;

    id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_alu_op(i_alu_op),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_pc(i_pc),
        .i_op_a_sel(i_op_a_sel), .i_op_b_imm(i_op_b_imm), .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we),
        .i_is_load(i_is_load), .i_ex_fwd_valid(i_ex_fwd_valid), .i_ex_fwd_rd(i_ex_fwd_rd),
        .i_ex_fwd_data(i_ex_fwd_data), .i_ex_is_load(i_ex_is_load), .i_wb_fwd_valid(i_wb_fwd_valid),
        .i_wb_fwd_rd(i_wb_fwd_rd), .i_wb_fwd_data(i_wb_fwd_data), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_alu_op(o_alu_op), .o_operand_a(o_operand_a), .o_operand_b(o_operand_b),
        .o_rs2_fwd(o_rs2_fwd), .o_pc(o_pc), .o_imm(o_imm), .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we),
        .o_is_load(o_is_load)
    );

    always #5 clk = ~clk;

    // Value an instruction should see for a source register, from the forwarding rules.
    function automatic logic [DW-1:0] src_value(input logic [AW-1:0] rs, input logic [DW-1:0] rf);
        if (rs == 0) return '0;
        if (i_ex_fwd_valid && i_ex_fwd_rd == rs && !i_ex_is_load) return i_ex_fwd_data;
        if (i_wb_fwd_valid && i_wb_fwd_rd == rs) return i_wb_fwd_data;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = ALU_NOP; m_a = 0; m_b = 0; m_rs2 = 0;
        m_pc = 0; m_imm = 0; m_rd = 0; m_we = 0; m_load = 0;
    endtask

    // Decide what the next edge does to the held instruction.
    task automatic model_edge();
        bit dep, stall, can_move;
        dep = (i_rs1_used && i_rs1_addr == i_ex_fwd_rd) || (i_rs2_used && i_rs2_addr == i_ex_fwd_rd);
        stall = i_valid && i_ex_fwd_valid && i_ex_is_load && (i_ex_fwd_rd != 0) && dep;
        can_move = !m_valid || i_ready;
        exp_ready = can_move && !stall;
        if (i_flush || (can_move && !(i_valid && exp_ready))) begin
            m_valid = 0; m_op = ALU_NOP; m_we = 0; m_load = 0;
        end else if (can_move) begin
            m_valid = 1; m_op = i_alu_op; m_pc = i_pc; m_imm = i_imm;
            m_rd = i_rd_addr; m_we = i_rd_we; m_load = i_is_load;
            m_rs2 = src_value(i_rs2_addr, i_rs2_data);
            m_a = (i_op_a_sel == OPA_PC) ? i_pc :
                  (i_op_a_sel == OPA_ZERO) ? '0 : src_value(i_rs1_addr, i_rs1_data);
            m_b = i_op_b_imm ? i_imm : m_rs2;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        obs_ready = o_ready;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_rs1_used = 0; i_rs2_used = 0; i_op_b_imm = 0; i_rd_we = 0; i_is_load = 0;
        i_ex_fwd_valid = 0; i_ex_is_load = 0; i_wb_fwd_valid = 0; i_flush = 0; i_ready = 1;
        i_alu_op = ALU_NOP; i_op_a_sel = OPA_RS1; i_rs1_addr = 0; i_rs2_addr = 0; i_rd_addr = 0;
        i_ex_fwd_rd = 0; i_wb_fwd_rd = 0; i_rs1_data = 0; i_rs2_data = 0; i_imm = 0; i_pc = 0;
        i_ex_fwd_data = 0; i_wb_fwd_data = 0;
    endtask

    task automatic set_instr(input alu_op_t op, input logic [AW-1:0] rs1, input logic [DW-1:0] d1,
                             input logic [AW-1:0] rs2, input logic [DW-1:0] d2);
        i_valid = 1; i_alu_op = op; i_rs1_addr = rs1; i_rs1_data = d1; i_rs1_used = 1;
        i_rs2_addr = rs2; i_rs2_data = d2; i_rs2_used = 1; i_op_a_sel = OPA_RS1; i_op_b_imm = 0;
        i_rd_addr = 5'd4; i_rd_we = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #3;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_alu_op !== ALU_NOP) begin n_bad++; $display("FAIL reset_op: got %0d want %0d", o_alu_op, ALU_NOP); end
        n_cmp++; if (o_operand_a !== '0 || o_operand_b !== '0 || o_rd_we !== 1'b0 || o_is_load !== 1'b0) begin
            n_bad++; $display("FAIL reset_regs: a=%0h b=%0h we=%b ld=%b want all 0", o_operand_a, o_operand_b, o_rd_we, o_is_load); end
        @(negedge clk); rst = 0; model_reset(); #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_add();
        idle_inputs();
        set_instr(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7);
        tick();
        idle_inputs();
        n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", obs_ready); end
        n_cmp++; if (o_valid !== 1'b1 || o_alu_op !== ALU_ADD) begin
            n_bad++; $display("FAIL add_ctrl: valid=%b op=%0d want 1/%0d", o_valid, o_alu_op, ALU_ADD); end
        n_cmp++; if (o_operand_a !== 32'd5 || o_operand_b !== 32'd7) begin
            n_bad++; $display("FAIL add_operands: a=%0h b=%0h want 5/7", o_operand_a, o_operand_b); end
    endtask

    task automatic test_forward_priority();
        idle_inputs();
        set_instr(ALU_OR, 5'd1, 32'd5, 5'd1, 32'd5);
        i_ex_fwd_valid = 1; i_ex_fwd_rd = 5'd1; i_ex_fwd_data = 32'h100;
        i_wb_fwd_valid = 1; i_wb_fwd_rd = 5'd1; i_wb_fwd_data = 32'h200;
        tick();
        n_cmp++; if (o_operand_a !== 32'h100 || o_rs2_fwd !== 32'h100) begin
            n_bad++; $display("FAIL fwd_ex_prio: a=%0h rs2=%0h want 100/100", o_operand_a, o_rs2_fwd); end
        i_ex_fwd_rd = 5'd2;
        tick();
        n_cmp++; if (o_operand_a !== 32'h200) begin n_bad++; $display("FAIL fwd_wb: a=%0h want 200", o_operand_a); end
        i_rs1_addr = 0; i_rs1_data = 0; i_ex_fwd_rd = 0; i_wb_fwd_rd = 0;
        tick();
        n_cmp++; if (o_operand_a !== 32'h0) begin n_bad++; $display("FAIL fwd_x0: a=%0h want 0", o_operand_a); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        idle_inputs();
        set_instr(ALU_ADD, 5'd1, 32'd9, 5'd3, 32'd8);
        i_ex_fwd_valid = 1; i_ex_is_load = 1; i_ex_fwd_rd = 5'd3; i_ex_fwd_data = 32'hdead;
        tick();
        n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL lu_ready: got %b want 0", obs_ready); end
        n_cmp++; if (o_valid !== 1'b0 || o_alu_op !== ALU_NOP || o_rd_we !== 1'b0) begin
            n_bad++; $display("FAIL lu_bubble: valid=%b op=%0d we=%b want 0/0/0", o_valid, o_alu_op, o_rd_we); end
        i_ex_is_load = 0; i_ex_fwd_data = 32'h33;
        tick();
        n_cmp++; if (obs_ready !== 1'b1 || o_valid !== 1'b1 || o_operand_b !== 32'h33) begin
            n_bad++; $display("FAIL lu_accept: ready=%b valid=%b b=%0h want 1/1/33", obs_ready, o_valid, o_operand_b); end
        idle_inputs();
    endtask

    task automatic test_hold();
        logic [DW-1:0] a0, b0;
        alu_op_t op0;
        idle_inputs();
        set_instr(ALU_SUB, 5'd6, 32'd11, 5'd7, 32'd2);
        tick();
        a0 = o_operand_a; b0 = o_operand_b; op0 = o_alu_op;
        n_cmp++; if (a0 !== 32'd11 || op0 !== ALU_SUB) begin n_bad++; $display("FAIL hold_load: a=%0h op=%0d want b/%0d", a0, op0, ALU_SUB); end
        i_ready = 0;
        for (int k = 0; k < 3; k++) begin
            set_instr(ALU_XOR, 5'd8, $urandom, 5'd9, $urandom);
            i_ready = 0;
            tick();
            n_cmp++; if (obs_ready !== 1'b0 || o_valid !== 1'b1 || o_alu_op !== op0 || o_operand_a !== a0 || o_operand_b !== b0) begin
                n_bad++; $display("FAIL hold_stable: ready=%b valid=%b op=%0d a=%0h b=%0h want 0/1/%0d/%0h/%0h",
                                  obs_ready, o_valid, o_alu_op, o_operand_a, o_operand_b, op0, a0, b0); end
        end
        set_instr(ALU_AND, 5'd8, 32'h77, 5'd9, 32'h1);
        i_ready = 1;
        tick();
        n_cmp++; if (o_valid !== 1'b1 || o_alu_op !== ALU_AND || o_operand_a !== 32'h77) begin
            n_bad++; $display("FAIL hold_release: valid=%b op=%0d a=%0h want 1/%0d/77", o_valid, o_alu_op, o_operand_a, ALU_AND); end
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs();
        set_instr(ALU_SLT, 5'd1, 32'd1, 5'd2, 32'd2);
        tick();
        i_ready = 0;
        i_flush = 1;
        tick();
        n_cmp++; if (o_valid !== 1'b0 || o_alu_op !== ALU_NOP || o_rd_we !== 1'b0) begin
            n_bad++; $display("FAIL flush: valid=%b op=%0d we=%b want 0/0/0", o_valid, o_alu_op, o_rd_we); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_alu_op = alu_op_t'(4'($urandom_range(0, 10)));
            i_rs1_addr = 5'($urandom_range(0, 3)); i_rs2_addr = 5'($urandom_range(0, 3));
            i_rs1_used = 1'($urandom); i_rs2_used = 1'($urandom);
            i_rs1_data = $urandom; i_rs2_data = $urandom; i_imm = $urandom; i_pc = $urandom;
            i_op_a_sel = op_a_sel_t'(2'($urandom_range(0, 2))); i_op_b_imm = 1'($urandom);
            i_rd_addr = 5'($urandom); i_rd_we = 1'($urandom); i_is_load = 1'($urandom);
            i_ex_fwd_valid = 1'($urandom); i_ex_fwd_rd = 5'($urandom_range(0, 3));
            i_ex_fwd_data = $urandom; i_ex_is_load = ($urandom_range(0, 3) == 0);
            i_wb_fwd_valid = 1'($urandom); i_wb_fwd_rd = 5'($urandom_range(0, 3)); i_wb_fwd_data = $urandom;
            i_flush = ($urandom_range(0, 9) == 0); i_ready = ($urandom_range(0, 9) < 7);
            tick();
            n_cmp++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, obs_ready, exp_ready); end
            n_cmp++; if (o_valid !== m_valid || o_alu_op !== m_op || o_rd_we !== m_we || o_is_load !== m_load) begin
                n_bad++; $display("FAIL rnd_ctrl c=%0d: v/op/we/ld=%b/%0d/%b/%b want %b/%0d/%b/%b",
                                  c, o_valid, o_alu_op, o_rd_we, o_is_load, m_valid, m_op, m_we, m_load); end
            if (m_valid) begin
                n_cmp++; if (o_operand_a !== m_a || o_operand_b !== m_b || o_rs2_fwd !== m_rs2 ||
                             o_pc !== m_pc || o_imm !== m_imm || o_rd_addr !== m_rd) begin
                    n_bad++; $display("FAIL rnd_data c=%0d: a=%0h b=%0h s=%0h pc=%0h imm=%0h rd=%0d want %0h %0h %0h %0h %0h %0d",
                                      c, o_operand_a, o_operand_b, o_rs2_fwd, o_pc, o_imm, o_rd_addr,
                                      m_a, m_b, m_rs2, m_pc, m_imm, m_rd); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        set_instr(ALU_SRA, 5'd1, 32'hfff, 5'd2, 32'h3);
        tick();
        i_ready = 0;
        tick();
        #2;
        rst = 1;
        #1;
        model_reset();
        n_cmp++; if (o_valid !== 1'b0 || o_alu_op !== ALU_NOP || o_operand_a !== '0 || o_operand_b !== '0 || o_rd_we !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid: valid=%b op=%0d a=%0h b=%0h we=%b want all 0",
                              o_valid, o_alu_op, o_operand_a, o_operand_b, o_rd_we); end
        @(negedge clk);
        rst = 0;
        idle_inputs();
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", o_ready); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_add();
        test_forward_priority();
        test_load_use();
        test_hold();
        test_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
